// File: rtl/alu_mc_pkg.sv
// alu_mc shared definitions: opcodes, core selects, FSM states.
// Imported by the multi-cycle ALU top and its combinational core.
package alu_mc_pkg;

    localparam logic [3:0] OP_AND   = 4'b0000;
    localparam logic [3:0] OP_OR    = 4'b0001;
    localparam logic [3:0] OP_ADD   = 4'b0010;
    localparam logic [3:0] OP_SUB   = 4'b0110;
    localparam logic [3:0] OP_SLT   = 4'b0111;
    localparam logic [3:0] OP_NOR   = 4'b1100;
    localparam logic [3:0] OP_MULTU = 4'b1000;
    localparam logic [3:0] OP_DIVU  = 4'b1001;
    localparam logic [3:0] OP_MFHI  = 4'b1010;
    localparam logic [3:0] OP_MFLO  = 4'b1011;

    // low two opcode bits pick the core output path
    localparam logic [1:0] SEL_AND = 2'b00;
    localparam logic [1:0] SEL_OR  = 2'b01;
    localparam logic [1:0] SEL_ADD = 2'b10;
    localparam logic [1:0] SEL_SLT = 2'b11;

    typedef enum logic [1:0] {
        IDLE,
        MUL,
        DIV
    } state_t;

    function automatic logic op_core(input logic [3:0] op);
        case (op)
            OP_AND, OP_OR, OP_ADD,
            OP_SUB, OP_SLT, OP_NOR: return 1'b1;
            default:                return 1'b0;
        endcase
    endfunction

    function automatic logic op_addsub(input logic [3:0] op);
        return (op == OP_ADD) || (op == OP_SUB);
    endfunction

endpackage

// File: rtl/alu_core_n.sv
// Combinational WIDTH-bit ALU core: AND/OR/NOR/add/sub/SLT.
// Ripple of per-bit slices; op[3]/op[2] invert a/b, op[2] is carry-in.
module alu_core_n
    import alu_mc_pkg::*;
#(
    parameter int WIDTH = 32
) (
    input  logic [3:0]       op,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    output logic [WIDTH-1:0] y,
    output logic             ovf
);

    logic             ainv;
    logic             binv;
    logic [WIDTH-1:0] aa;
    logic [WIDTH-1:0] bb;
    logic [WIDTH-1:0] s;
    logic [WIDTH:0]   c;
    logic             set;

    assign ainv = op[3];
    assign binv = op[2];
    assign aa   = a ^ {WIDTH{ainv}};
    assign bb   = b ^ {WIDTH{binv}};
    assign c[0] = binv;

    genvar i;
    generate
        for (i = 0; i < WIDTH; i++) begin : g_bit
            assign s[i]   = aa[i] ^ bb[i] ^ c[i];
            assign c[i+1] = (aa[i] & bb[i])
                          | (c[i] & (aa[i] ^ bb[i]));
        end
    endgenerate

    assign ovf = c[WIDTH-1] ^ c[WIDTH];
    assign set = s[WIDTH-1] ^ ovf;

    always_comb begin
        y = '0;
        unique case (op[1:0])
            SEL_AND: y = aa & bb;
            SEL_OR:  y = aa | bb;
            SEL_ADD: y = s;
            SEL_SLT: y = {{(WIDTH-1){1'b0}}, set};
            default: y = '0;
        endcase
    end

endmodule

// File: rtl/alu_mc.sv
// Multi-cycle integer ALU for the EX stage: single-cycle core ops,
// iterative MULTU/DIVU into HI/LO, valid/ready handshake.
module alu_mc
    import alu_mc_pkg::*;
#(
    parameter int WIDTH = 32
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [3:0]       op,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    output logic             out_valid,
    output logic [WIDTH-1:0] result,
    output logic             zero,
    output logic             overflow,
    output logic [WIDTH-1:0] hi,
    output logic [WIDTH-1:0] lo
);

    localparam int CNT_W = $clog2(WIDTH) + 1;

    state_t               state;
    state_t               state_nx;
    logic [CNT_W-1:0]     cnt;
    logic [2*WIDTH-1:0]   acc;
    logic [2*WIDTH-1:0]   acc_nx;
    logic [WIDTH-1:0]     opd;

    logic                 accept;
    logic                 start_mul;
    logic                 start_div;
    logic                 last;

    logic [WIDTH-1:0]     core_y;
    logic                 core_ovf;
    logic                 is_core;
    logic                 is_mfhi;
    logic                 is_mflo;
    logic                 sc_ok;
    logic                 sc_ovf;
    logic [WIDTH-1:0]     sc_res;

    logic [WIDTH:0]       mul_sum;
    logic [WIDTH:0]       rem_sh;
    logic [WIDTH:0]       diff;
    logic                 nb;

    alu_core_n #(
        .WIDTH(WIDTH)
    ) u_core (
        .op (op),
        .a  (a),
        .b  (b),
        .y  (core_y),
        .ovf(core_ovf)
    );

    assign accept    = in_valid & in_ready;
    assign start_mul = accept & (op == OP_MULTU);
    assign start_div = accept & (op == OP_DIVU);
    assign last      = (cnt == CNT_W'(1));

    always_ff @(posedge clk) begin
        if (!rst_n) state <= IDLE;
        else        state <= state_nx;
    end

    always_comb begin
        state_nx = state;
        unique case (state)
            IDLE: begin
                if (start_mul)      state_nx = MUL;
                else if (start_div) state_nx = DIV;
            end
            MUL, DIV: if (last) state_nx = IDLE;
            default:  state_nx = IDLE;
        endcase
    end

    always_comb begin
        in_ready = (state == IDLE);
    end

    // one multiply or restoring-divide step on the accumulator
    always_comb begin
        mul_sum = {1'b0, acc[2*WIDTH-1:WIDTH]}
                + (acc[0] ? {1'b0, opd} : '0);
        rem_sh  = {acc[2*WIDTH-1:WIDTH], acc[WIDTH-1]};
        diff    = rem_sh - {1'b0, opd};
        nb      = ~diff[WIDTH];
        acc_nx  = acc;
        unique case (state)
            MUL: acc_nx = {mul_sum, acc[WIDTH-1:1]};
            DIV: acc_nx = {nb ? diff[WIDTH-1:0]
                              : rem_sh[WIDTH-1:0],
                           acc[WIDTH-2:0], nb};
            default: acc_nx = acc;
        endcase
    end

    always_comb begin
        is_core = op_core(op);
        is_mfhi = (op == OP_MFHI);
        is_mflo = (op == OP_MFLO);
        sc_ok   = is_core | is_mfhi | is_mflo;
        sc_res  = '0;
        sc_ovf  = 1'b0;
        unique case (1'b1)
            is_mfhi: sc_res = hi;
            is_mflo: sc_res = lo;
            is_core: begin
                sc_res = core_y;
                sc_ovf = op_addsub(op) & core_ovf;
            end
            default: sc_res = '0;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            out_valid <= 1'b0;
            result    <= '0;
            zero      <= 1'b0;
            overflow  <= 1'b0;
            hi        <= '0;
            lo        <= '0;
            cnt       <= '0;
            acc       <= '0;
            opd       <= '0;
        end else begin
            out_valid <= 1'b0;
            unique case (state)
                IDLE: begin
                    if (start_mul | start_div) begin
                        cnt <= CNT_W'(WIDTH);
                        opd <= start_mul ? a : b;
                        acc <= {{WIDTH{1'b0}},
                                start_mul ? b : a};
                    end else if (accept) begin
                        out_valid <= 1'b1;
                        result    <= sc_res;
                        zero      <= sc_ok & (sc_res == '0);
                        overflow  <= sc_ovf;
                    end
                end
                MUL, DIV: begin
                    cnt <= cnt - CNT_W'(1);
                    acc <= acc_nx;
                    if (last) begin
                        hi        <= acc_nx[2*WIDTH-1:WIDTH];
                        lo        <= acc_nx[WIDTH-1:0];
                        result    <= acc_nx[WIDTH-1:0];
                        zero      <= (acc_nx[WIDTH-1:0] == '0);
                        overflow  <= 1'b0;
                        out_valid <= 1'b1;
                    end
                end
                default: cnt <= '0;
            endcase
        end
    end

endmodule

// File: tb/tb_alu_mc.sv
// Directed bench for alu_mc: vector table for single-cycle ops,
// hand sequences for MULTU/DIVU, mid-op reset and an 8-bit instance.
module tb_alu_mc;
    import alu_mc_pkg::*;

    logic        clk;
    logic        rst_n;
    logic        in_valid;
    logic        in_ready;
    logic [3:0]  op;
    logic [31:0] a;
    logic [31:0] b;
    logic        out_valid;
    logic [31:0] result;
    logic        zero;
    logic        overflow;
    logic [31:0] hi;
    logic [31:0] lo;

    logic        v8;
    logic        rdy8;
    logic [3:0]  op8;
    logic [7:0]  a8;
    logic [7:0]  b8;
    logic        ov8;
    logic [7:0]  res8;
    logic        z8;
    logic        of8;
    logic [7:0]  hi8;
    logic [7:0]  lo8;

    int errors = 0;
    int checks = 0;

    alu_mc #(.WIDTH(32)) dut (
        .clk(clk), .rst_n(rst_n),
        .in_valid(in_valid), .in_ready(in_ready),
        .op(op), .a(a), .b(b),
        .out_valid(out_valid), .result(result),
        .zero(zero), .overflow(overflow),
        .hi(hi), .lo(lo)
    );

    alu_mc #(.WIDTH(8)) dut8 (
        .clk(clk), .rst_n(rst_n),
        .in_valid(v8), .in_ready(rdy8),
        .op(op8), .a(a8), .b(b8),
        .out_valid(ov8), .result(res8),
        .zero(z8), .overflow(of8),
        .hi(hi8), .lo(lo8)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic [3:0]  op;
        logic [31:0] a;
        logic [31:0] b;
        logic [31:0] res;
        logic        z;
        logic        ov;
    } vec_t;

    vec_t vt[14];

    task automatic chk(input string name,
                       input logic [63:0] act,
                       input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h want %0h",
                     name, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic sc32(input logic [3:0] o,
                        input logic [31:0] x,
                        input logic [31:0] y);
        in_valid = 1'b1;
        op = o; a = x; b = y;
        tick();
        in_valid = 1'b0;
    endtask

    // start a long op, wait (bounded) for its out_valid pulse
    task automatic long32(input logic [3:0] o,
                          input logic [31:0] x,
                          input logic [31:0] y,
                          input bit hold,
                          output int lat,
                          output int busy);
        in_valid = 1'b1;
        op = o; a = x; b = y;
        tick();
        if (hold) op = OP_ADD;
        else      in_valid = 1'b0;
        lat = 0;
        busy = 0;
        while (!out_valid && lat < 100) begin
            if (!in_ready) busy++;
            tick();
            lat++;
        end
        in_valid = 1'b0;
    endtask

    task automatic long8(input logic [3:0] o,
                         input logic [7:0] x,
                         input logic [7:0] y,
                         output int lat);
        v8 = 1'b1;
        op8 = o; a8 = x; b8 = y;
        tick();
        v8 = 1'b0;
        lat = 0;
        while (!ov8 && lat < 50) begin
            tick();
            lat++;
        end
    endtask

    initial begin
        int lat;
        int busy;
        int extra;

        vt[0]  = '{OP_ADD, 32'h7FFFFFFF, 32'h1,
                   32'h80000000, 1'b0, 1'b1};
        vt[1]  = '{OP_SUB, 32'h5, 32'h5,
                   32'h0, 1'b1, 1'b0};
        vt[2]  = '{OP_SLT, 32'hFFFFFFFF, 32'h1,
                   32'h1, 1'b0, 1'b0};
        vt[3]  = '{OP_AND, 32'hF0F0, 32'hFF00,
                   32'hF000, 1'b0, 1'b0};
        vt[4]  = '{OP_OR, 32'hF0F0, 32'hFF00,
                   32'hFFF0, 1'b0, 1'b0};
        vt[5]  = '{OP_NOR, 32'h0, 32'h0,
                   32'hFFFFFFFF, 1'b0, 1'b0};
        vt[6]  = '{OP_NOR, 32'hFFFF0000, 32'h0000FFFF,
                   32'h0, 1'b1, 1'b0};
        vt[7]  = '{OP_SUB, 32'h80000000, 32'h1,
                   32'h7FFFFFFF, 1'b0, 1'b1};
        vt[8]  = '{OP_SLT, 32'h80000000, 32'h7FFFFFFF,
                   32'h1, 1'b0, 1'b0};
        vt[9]  = '{OP_SLT, 32'h1, 32'hFFFFFFFF,
                   32'h0, 1'b1, 1'b0};
        vt[10] = '{OP_ADD, 32'hFFFFFFFF, 32'h1,
                   32'h0, 1'b1, 1'b0};
        vt[11] = '{4'b0011, 32'h5, 32'h5,
                   32'h0, 1'b0, 1'b0};
        vt[12] = '{4'b1111, 32'h1, 32'h1,
                   32'h0, 1'b0, 1'b0};
        vt[13] = '{OP_MFLO, 32'h0, 32'h0,
                   32'h0, 1'b1, 1'b0};

        rst_n = 1'b0;
        in_valid = 1'b0; op = '0; a = '0; b = '0;
        v8 = 1'b0; op8 = '0; a8 = '0; b8 = '0;
        repeat (3) @(posedge clk);
        #1;
        chk("rst in_ready", 64'(in_ready), 64'd1);
        chk("rst out_valid", 64'(out_valid), 64'd0);
        chk("rst result", 64'(result), 64'd0);
        chk("rst zero", 64'(zero), 64'd0);
        chk("rst overflow", 64'(overflow), 64'd0);
        chk("rst hi", 64'(hi), 64'd0);
        chk("rst lo", 64'(lo), 64'd0);
        chk("rst8 in_ready", 64'(rdy8), 64'd1);
        chk("rst8 hi/lo", {48'd0, hi8, lo8}, 64'd0);
        rst_n = 1'b1;

        // back-to-back single-cycle accepts
        for (int i = 0; i < 14; i++) begin
            in_valid = 1'b1;
            op = vt[i].op; a = vt[i].a; b = vt[i].b;
            tick();
            chk($sformatf("vec%0d valid", i),
                64'(out_valid), 64'd1);
            chk($sformatf("vec%0d ready", i),
                64'(in_ready), 64'd1);
            chk($sformatf("vec%0d result", i),
                64'(result), 64'(vt[i].res));
            chk($sformatf("vec%0d zero", i),
                64'(zero), 64'(vt[i].z));
            chk($sformatf("vec%0d ovf", i),
                64'(overflow), 64'(vt[i].ov));
        end
        in_valid = 1'b0;
        tick();
        chk("idle out_valid", 64'(out_valid), 64'd0);

        // MULTU with ADD held on the inputs while busy
        long32(OP_MULTU, 32'hFFFFFFFF, 32'hFFFFFFFF,
               1'b1, lat, busy);
        chk("mul latency", 64'(lat), 64'd32);
        chk("mul busy cycles", 64'(busy), 64'd32);
        chk("mul ready after", 64'(in_ready), 64'd1);
        chk("mul hi", 64'(hi), 64'hFFFFFFFE);
        chk("mul lo", 64'(lo), 64'h1);
        chk("mul result", 64'(result), 64'h1);
        chk("mul zero/ovf", {62'd0, zero, overflow}, 64'd0);
        tick();
        chk("mul single pulse", 64'(out_valid), 64'd0);
        sc32(OP_MFHI, 32'h0, 32'h0);
        chk("mfhi after mul", 64'(result), 64'hFFFFFFFE);

        long32(OP_DIVU, 32'd100, 32'd7, 1'b0, lat, busy);
        chk("div latency", 64'(lat), 64'd32);
        chk("div lo", 64'(lo), 64'd14);
        chk("div hi", 64'(hi), 64'd2);
        chk("div result", 64'(result), 64'd14);

        long32(OP_DIVU, 32'h1234, 32'h0, 1'b0, lat, busy);
        chk("div0 latency", 64'(lat), 64'd32);
        chk("div0 lo", 64'(lo), 64'hFFFFFFFF);
        chk("div0 hi", 64'(hi), 64'h1234);
        sc32(OP_MFHI, 32'h0, 32'h0);
        chk("mfhi after div0", 64'(result), 64'h1234);
        sc32(OP_MFLO, 32'h0, 32'h0);
        chk("mflo after div0", 64'(result), 64'hFFFFFFFF);
        sc32(OP_ADD, 32'h1, 32'h1);
        chk("hi kept by add", 64'(hi), 64'h1234);

        // reset during cycle 10 of a multiply
        sc32(OP_MULTU, 32'd3, 32'd5);
        repeat (9) tick();
        rst_n = 1'b0;
        tick();
        chk("midrst ready", 64'(in_ready), 64'd1);
        chk("midrst out_valid", 64'(out_valid), 64'd0);
        chk("midrst hi", 64'(hi), 64'd0);
        chk("midrst lo", 64'(lo), 64'd0);
        rst_n = 1'b1;
        sc32(OP_ADD, 32'd2, 32'd3);
        chk("post-rst add valid", 64'(out_valid), 64'd1);
        chk("post-rst add", 64'(result), 64'd5);
        extra = 0;
        for (int i = 0; i < 40; i++) begin
            tick();
            if (out_valid) extra++;
        end
        chk("abandoned op pulses", 64'(extra), 64'd0);
        chk("abandoned op lo", 64'(lo), 64'd0);

        // 8-bit instance
        long8(OP_MULTU, 8'hFF, 8'h02, lat);
        chk("w8 mul latency", 64'(lat), 64'd8);
        chk("w8 mul hi", 64'(hi8), 64'h01);
        chk("w8 mul lo", 64'(lo8), 64'hFE);
        long8(OP_DIVU, 8'd200, 8'd13, lat);
        chk("w8 div latency", 64'(lat), 64'd8);
        chk("w8 div lo", 64'(lo8), 64'd15);
        chk("w8 div hi", 64'(hi8), 64'd5);
        v8 = 1'b1;
        op8 = OP_ADD; a8 = 8'h80; b8 = 8'h80;
        tick();
        v8 = 1'b0;
        chk("w8 add valid", 64'(ov8), 64'd1);
        chk("w8 add result", 64'(res8), 64'h00);
        chk("w8 add zero", 64'(z8), 64'd1);
        chk("w8 add ovf", 64'(of8), 64'd1);

        $display("Result: errors=%0d of %0d checks",
                 errors, checks);
        $finish;
    end

endmodule
